// File: rtl/ball_spawner_if.sv
// ball_spawner_if: spawn offer handshake between the spawner and the ball manager
interface ball_spawner_if #(parameter int SIZE_BITS = 10);
  logic                 spawn_valid;
  logic                 spawn_ready;
  logic [SIZE_BITS-1:0] spawn_x;
  logic                 spawn_dir;
  modport master (output spawn_valid, spawn_x, spawn_dir, input spawn_ready);
  modport slave  (input spawn_valid, spawn_x, spawn_dir, output spawn_ready);
endinterface

// File: rtl/ball_spawner.sv
// ball_spawner: triggers the x generator, clamps its value and offers a spawn; SPAWNER_RAND_DIR_EN selects random direction
module ball_spawner #(
  parameter int SIZE_BITS    = 10,
  parameter int X_MIN        = 16,
  parameter int X_MAX        = 591,
  parameter int MAX_BALLS    = 4,
  parameter int COOLDOWN_CYC = 8
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             spawn_req,
  input  logic                             clear,
  input  logic                             ball_popped,
  input  logic [SIZE_BITS-1:0]             rand_val,
  output logic                             rand_trig,
  output logic [$clog2(MAX_BALLS+1)-1:0]   active_cnt,
  output logic                             busy,
  ball_spawner_if.master                   sp
);
  localparam int CW = $clog2(MAX_BALLS+1);
  localparam int DW = $clog2(COOLDOWN_CYC+1);
  localparam logic [SIZE_BITS-1:0] XLO = SIZE_BITS'(X_MIN);
  localparam logic [SIZE_BITS-1:0] XHI = SIZE_BITS'(X_MAX);
  localparam logic [CW-1:0] MAXC = CW'(MAX_BALLS);
  localparam logic [DW-1:0] CLD = DW'(COOLDOWN_CYC-1);
  typedef enum logic [2:0] {IDLE, TRIG, CAPT, OFFER, COOL} state_t;
  state_t state;
  logic pending, tog, hs, dec;
  logic [DW-1:0] cool;
  logic [SIZE_BITS-1:0] clamped;
  // handshake, effective pop and playfield clamp
  always_comb begin
    hs = sp.spawn_valid & sp.spawn_ready;
    dec = ball_popped & (active_cnt != '0);
    clamped = rand_val < XLO ? XLO : rand_val > XHI ? XHI : rand_val;
  end
  // live-ball count: simultaneous spawn and pop cancel out
  always_ff @(posedge clk)
    if (reset || clear) active_cnt <= '0;
    else if (hs && !dec && active_cnt != MAXC) active_cnt <= active_cnt + 1'b1;
    else if (dec && !hs) active_cnt <= active_cnt - 1'b1;
  // spawn sequencer with registered trigger, offer and busy outputs
  always_ff @(posedge clk)
    if (reset) begin
      state <= IDLE;
      pending <= 1'b0;
      cool <= '0;
      tog <= 1'b0;
      rand_trig <= 1'b0;
      busy <= 1'b0;
      sp.spawn_valid <= 1'b0;
      sp.spawn_x <= '0;
      sp.spawn_dir <= 1'b0;
    end else if (clear) begin
      state <= IDLE;
      pending <= 1'b0;
      cool <= '0;
      tog <= 1'b0;
      rand_trig <= 1'b0;
      busy <= 1'b0;
      sp.spawn_valid <= 1'b0;
    end else begin
      rand_trig <= 1'b0;
      if (state != IDLE && spawn_req) pending <= 1'b1;
      case (state)
        IDLE:
          if ((spawn_req || pending) && active_cnt < MAXC) begin
            state <= TRIG;
            pending <= 1'b0;
            rand_trig <= 1'b1;
            busy <= 1'b1;
          end else if (spawn_req) pending <= 1'b1;
        TRIG: state <= CAPT;
        CAPT: begin
          sp.spawn_x <= clamped;
`ifdef SPAWNER_RAND_DIR_EN
          sp.spawn_dir <= rand_val[0];
`else
          sp.spawn_dir <= tog;
`endif
          sp.spawn_valid <= 1'b1;
          state <= OFFER;
        end
        OFFER:
          if (hs) begin
            sp.spawn_valid <= 1'b0;
            cool <= CLD;
            tog <= ~tog;
            state <= COOL;
          end
        COOL:
          if (cool == '0) begin
            state <= IDLE;
            busy <= 1'b0;
          end else cool <= cool - 1'b1;
        default: state <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_ball_spawner.sv
// tb_ball_spawner: randomized scoreboard bench for ball_spawner with a generator model
module tb_ball_spawner;
  localparam int SB = 10, XMIN = 16, XMAX = 591, MAXB = 4, CD = 8;
  logic clk = 0, reset = 1, spawn_req = 0, clear = 0, ball_popped = 0;
  logic [SB-1:0] rand_val = 0;
  logic rand_trig, busy;
  logic [2:0] active_cnt;
  ball_spawner_if #(.SIZE_BITS(SB)) sif();
  ball_spawner dut (
    .clk(clk), .reset(reset), .spawn_req(spawn_req), .clear(clear),
    .ball_popped(ball_popped), .rand_val(rand_val), .rand_trig(rand_trig),
    .active_cnt(active_cnt), .busy(busy), .sp(sif)
  );
  always #5 clk = ~clk;

  typedef struct {int x; int d;} exp_t;
  exp_t q[$];
  int vals[$];
  int vec = 0, bad = 0;
  int cyc = 0, mcnt = 0, hs_cnt = 0, ntrig = 0, last_trig = -100, trig_cyc = -100;
  logic pv = 0, phs = 0;
  logic [SB-1:0] px = 0;

  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    vec++;
    if (a !== e) begin
      bad++;
      $display("FAIL %s actual=%0d expected=%0d", n, a, e);
    end
  endtask

  function automatic int clampf(input int v);
    return v < XMIN ? XMIN : v > XMAX ? XMAX : v;
  endfunction

  function automatic int pick();
    int e[8] = '{0, 15, 16, 17, 590, 591, 592, 1023};
    return $urandom_range(0, 3) == 0 ? e[$urandom_range(0, 7)] : int'($urandom_range(0, 1023));
  endfunction

  // generator model: latches a new value on the edge ending the trigger pulse
  always @(posedge clk) begin
    int v, d;
    if (rand_trig && !reset && !clear) begin
      v = vals.size() != 0 ? vals.pop_front() : pick();
`ifdef SPAWNER_RAND_DIR_EN
      d = v & 1;
`else
      d = hs_cnt & 1;
`endif
      rand_val <= v[SB-1:0];
      q.push_back('{clampf(v), d});
    end
  end

  // monitor: live-ball model, trigger spacing, latency, stability and offer contents
  always @(negedge clk) begin
    exp_t e;
    logic hs;
    cyc++;
    if (reset) begin
      mcnt = 0; hs_cnt = 0; pv = 0; phs = 0; last_trig = -100;
      q.delete();
    end else begin
      chk("active_cnt", active_cnt, mcnt);
      if (rand_trig) begin
        chk("trig_gap", cyc - last_trig >= CD + 3, 1);
        chk("trig_below_max", mcnt < MAXB, 1);
        chk("busy_in_trig", busy, 1);
        last_trig = cyc; trig_cyc = cyc; ntrig++;
      end
      if (sif.spawn_valid && !pv) chk("latency", cyc - trig_cyc, 2);
      if (sif.spawn_valid && pv && !phs) chk("x_stable", sif.spawn_x, px);
      hs = sif.spawn_valid && sif.spawn_ready && !clear;
      if (hs) begin
        if (q.size() == 0) chk("unexpected_spawn", 1, 0);
        else begin
          e = q.pop_front();
          chk("spawn_x", sif.spawn_x, e.x);
          chk("spawn_dir", sif.spawn_dir, e.d);
        end
        hs_cnt++;
      end
      pv = sif.spawn_valid; phs = hs; px = sif.spawn_x;
      if (clear) begin
        mcnt = 0; hs_cnt = 0; last_trig = -100;
        q.delete();
      end else if (hs && !(ball_popped && mcnt > 0)) mcnt++;
      else if (!hs && ball_popped && mcnt > 0) mcnt--;
    end
  end

  task automatic tick(input int n = 1);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic wait_for(input int kind, input int lim, output int n);
    n = 0;
    for (int i = 1; i <= lim; i++) begin
      @(negedge clk);
      if ((kind == 0 && sif.spawn_valid) || (kind == 1 && !busy) ||
          (kind == 2 && rand_trig) || (kind == 3 && active_cnt == 3'(MAXB))) begin
        n = i;
        break;
      end
    end
  endtask

  task automatic pulse_req();
    spawn_req = 1; tick(); spawn_req = 0;
  endtask

  task automatic pop();
    ball_popped = 1; tick(); ball_popped = 0;
  endtask

  initial begin
    int n, n0;
    int tv[3] = '{5, 1000, 591};
    int dv[3] = '{301, 300, 301};
`ifdef SPAWNER_RAND_DIR_EN
    int de[3] = '{1, 0, 1};
`else
    int de[3] = '{0, 1, 0};
`endif
    sif.spawn_ready = 0;
    tick(3);
    reset = 0;
    @(negedge clk);
    chk("rst_trig", rand_trig, 0);
    chk("rst_valid", sif.spawn_valid, 0);
    chk("rst_x", sif.spawn_x, 0);
    chk("rst_dir", sif.spawn_dir, 0);
    chk("rst_cnt", active_cnt, 0);
    chk("rst_busy", busy, 0);
    tick();
    vals.push_back(300);
    sif.spawn_ready = 1;
    pulse_req();
    wait_for(0, 10, n);
    chk("t1_valid_seen", n != 0, 1);
    wait_for(1, 40, n);
    chk("t1_cool_len", n, CD + 1);
    chk("t1_cnt", active_cnt, 1);
    tick();
    for (int i = 0; i < 3; i++) begin
      vals.push_back(tv[i]);
      pulse_req();
      wait_for(0, 10, n);
      chk("t2_valid_seen", n != 0, 1);
      wait_for(1, 40, n);
      chk("t2_idle_seen", n != 0, 1);
      tick();
      pop();
    end
    sif.spawn_ready = 0;
    vals.push_back(123);
    pulse_req();
    wait_for(0, 10, n);
    chk("t3_valid_seen", n != 0, 1);
    n0 = ntrig;
    tick(20);
    chk("t3_no_retrig", ntrig - n0, 0);
    chk("t3_valid_held", sif.spawn_valid, 1);
    sif.spawn_ready = 1;
    wait_for(1, 40, n);
    tick();
    clear = 1; tick(); clear = 0;
    spawn_req = 1;
    wait_for(3, 200, n);
    chk("t4_reach_max", n != 0, 1);
    tick();
    spawn_req = 0;
    wait_for(1, 40, n);
    chk("t4_idle_at_max", n != 0, 1);
    n0 = ntrig;
    tick(15);
    chk("t4_blocked", ntrig - n0, 0);
    chk("t4_busy_low", busy, 0);
    sif.spawn_ready = 0;
    pop();
    wait_for(2, 6, n);
    chk("t4_trig_after_pop", n, 2);
    wait_for(0, 10, n);
    tick();
    sif.spawn_ready = 1; ball_popped = 1;
    tick();
    sif.spawn_ready = 0; ball_popped = 0;
    @(negedge clk);
    chk("t4_pop_and_hs", active_cnt, 3);
    wait_for(1, 40, n);
    tick();
    pulse_req();
    wait_for(0, 10, n);
    tick();
    clear = 1; sif.spawn_ready = 1;
    tick();
    clear = 0; sif.spawn_ready = 0;
    @(negedge clk);
    chk("t5_valid_dropped", sif.spawn_valid, 0);
    chk("t5_cnt_cleared", active_cnt, 0);
    chk("t5_busy", busy, 0);
    tick();
    sif.spawn_ready = 1;
    for (int i = 0; i < 3; i++) begin
      vals.push_back(dv[i]);
      pulse_req();
      wait_for(0, 10, n);
      chk("t6_dir", sif.spawn_dir, de[i]);
      wait_for(1, 40, n);
      tick();
    end
    clear = 1; tick(); clear = 0;
    for (int i = 0; i < 3000; i++) begin
      spawn_req = $urandom_range(0, 3) == 0;
      sif.spawn_ready = $urandom_range(0, 2) != 0;
      ball_popped = $urandom_range(0, 5) == 0;
      clear = $urandom_range(0, 299) == 0;
      tick();
    end
    spawn_req = 0; clear = 0; ball_popped = 0; sif.spawn_ready = 1;
    tick(30);
    $display("== %0d vectors applied, %0d miscompares ==", vec, bad);
    $finish;
  end
endmodule
